lim_digit_counter: RTL and testbench
====================================

# lim_digit_counter

Parametrised multi-digit limited counter for score and timer displays. It is the sequential successor to the single-digit modulo-L incrementor. The block holds DIGITS registered digits and supports per-position modulus (even/odd positions, e.g. 10/6 for mm:ss), up/down counting, parallel load with clamping, and a wrap or saturate mode. Its output feeds the seven-segment display driver; its terminal-count output can chain further counters or end-of-game logic.

## Interface
- DIGITS, 4, number of digit positions (≥1); digit 0 is least significant.
- L_LO, 10, modulus of even positions (0, 2, …); range 2..16.
- L_HI, 6, modulus of odd positions (1, 3, …); range 2..16.
- SAT, 0, 0 = wrap at terminal count; 1 = hold at terminal count.
- N, $clog2(max(L_LO,L_HI)), bits per digit (derived; not overridden).
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  1  count-enable for one step this cycle.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load request.
- load_val  in  DIGITS*N  load value; digit k in bits [k*N +: N].
- count  out  DIGITS*N  registered counter value, same packing.
- tc  out  1  combinational terminal count: chain carry/borrow out this cycle.
- wrap  out  1  registered one-cycle pulse; the previous edge wrapped the chain.

## Operation
- Priority at each rising clk: reset > load > en > hold.
- reset: count=0, wrap=0.
- load: each digit k ← min(load_val digit, L_k−1). This is saturating clamp, so an out-of-range digit becomes the position maximum. wrap ← 0.
- en & up: digit 0 adds 1. A digit at L_k−1 receiving carry becomes 0 and passes carry to k+1. Carry ripples through all digits in one cycle.
- en & ~up: digit 0 subtracts 1. A digit at 0 receiving borrow becomes L_k−1 and passes borrow.
- A digit register holding a value ≥ L_k is treated as L_k−1 by the arithmetic. This cannot occur after reset or load; it is defensive only.
- tc = en & ~load & ~reset & (up ? all digits at L_k−1 : all digits 0).
- SAT=0 with tc: count wraps (all 0 going up, all L_k−1 going down); wrap ← 1 on that edge.
- SAT=1 with tc: count holds; wrap stays 0; tc still asserted.
- Any edge without a wrap sets wrap ← 0, so wrap is never high for two consecutive cycles unless consecutive wraps occur.
- DIGITS=1 degenerates to a single registered modulo-L_LO counter.

## Timing
- Reset values: count=0, wrap=0. tc follows its combinational equation, which is 0 while reset is high.
- count latency: 1 cycle from en/load to the new value.
- tc: zero latency, valid in the same cycle as en.
- wrap: asserted in the cycle after the wrapping edge, for 1 cycle.
- load and en together: load wins, tc=0, no count step.
- reset mid-count: takes effect on the next edge regardless of en/load.
- up may change every cycle; there is no direction-change penalty.
- The critical path is the DIGITS-long carry ripple. A single-cycle ripple is required; do not pipeline it.

## Structure
- Shared package/include: digit-limit function lim_of(k) returning L_LO or L_HI by parity, DIGIT_W derivation, and the SAT mode constants.
- Sub-module lim_digit (combinational): inputs value, ci, up, limit; outputs next value and co/bo with saturating input treatment. Instantiate it DIGITS times in a generate loop, chaining co/bo to ci.
- Top level: digit register array, load clamp, priority mux, tc reduction, wrap register. Target size is ~150–250 RTL lines.

## Test plan
All scenarios use DIGITS=4, L_LO=10, L_HI=6, N=4, values in hex per digit.
- Reset: assert reset 2 cycles with en=1, up=1 → count=0x0000, wrap=0, tc=0.
- Up with carry: load 0x0959, then en=1 up=1 → count=0x1000 next cycle, tc=0. Next: load 0x5958, en 2 cycles → 0x5959 (tc=0), then tc=1 in the cycle at 0x5959 → 0x0000, wrap=1 for exactly one cycle.
- Down with borrow: load 0x1000, en up=0 → 0x0959. From 0x0000, en up=0 → tc=1, count=0x5959, wrap=1.
- Clamp: load 0x7FAC → count=0x5959. Then load 0x0000 with en=1 on the same cycle → 0x0000, tc=0.
- SAT=1 instance: at 0x5959, en up=1 for 3 cycles → count stays 0x5959, tc=1 each cycle, wrap=0. At 0x0000 going down: holds, tc=1.
- Reset mid-operation: counting up from 0x0345, assert reset with en=1 and load=1 → 0x0000 next edge, wrap=0. Random en/up/load for 10k cycles checked against a reference model.

Source files
------------

// File: rtl/lim_digit_counter_pkg.sv
// Shared constants and helpers for the multi-digit limited counter:
// per-position modulus selection, digit width derivation and mode constants.
package lim_digit_counter_pkg;

    localparam bit SAT_WRAP = 1'b0;
    localparam bit SAT_HOLD = 1'b1;

    // Even positions use l_lo, odd positions use l_hi (e.g. 10/6 for mm:ss).
    function automatic int lim_of(input int k, input int l_lo, input int l_hi);
        return ((k % 2) == 0) ? l_lo : l_hi;
    endfunction

    function automatic int digit_w(input int l_lo, input int l_hi);
        return $clog2((l_lo > l_hi) ? l_lo : l_hi);
    endfunction

endpackage

// File: rtl/lim_digit.sv
// One combinational digit slice: steps a digit by the incoming carry/borrow
// and reports carry/borrow out. Out-of-range values behave as limit-1.
module lim_digit #(
    parameter int N = 4
) (
    input  logic [N-1:0] value,
    input  logic         ci,
    input  logic         up,
    input  logic [N:0]   limit,
    output logic [N-1:0] next_val,
    output logic         co
);

    logic [N-1:0] top_v;
    logic [N-1:0] eff;

    always_comb begin
        top_v    = N'(limit - (N+1)'(1));
        eff      = ({1'b0, value} >= limit) ? top_v : value;
        next_val = eff;
        co       = 1'b0;
        if (ci) begin
            if (up) begin
                if (eff == top_v) begin
                    next_val = '0;
                    co       = 1'b1;
                end else begin
                    next_val = eff + N'(1);
                end
            end else begin
                if (eff == '0) begin
                    next_val = top_v;
                    co       = 1'b1;
                end else begin
                    next_val = eff - N'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lim_digit_counter.sv
// Multi-digit limited up/down counter with per-position modulus, clamped
// parallel load, wrap/saturate mode, terminal count and a wrap pulse.
module lim_digit_counter
    import lim_digit_counter_pkg::*;
#(
    parameter int   DIGITS = 4,
    parameter int   L_LO   = 10,
    parameter int   L_HI   = 6,
    parameter bit   SAT    = SAT_WRAP,
    localparam int  N      = digit_w(L_LO, L_HI)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [DIGITS*N-1:0] load_val,
    output logic [DIGITS*N-1:0] count,
    output logic              tc,
    output logic              wrap
);

    logic [DIGITS*N-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [DIGITS*N-1:0] load_clamp;
    logic [DIGITS*N-1:0] step_val;
    logic [DIGITS:0]     carry;

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam int           LIM  = lim_of(gi, L_LO, L_HI);
            localparam logic [N-1:0] MAXV = N'(LIM - 1);
            localparam logic [N:0]   LIMW = (N+1)'(LIM);

            // Saturating clamp: an out-of-range load digit becomes the position maximum.
            assign load_clamp[gi*N +: N] =
                (load_val[gi*N +: N] > MAXV) ? MAXV : load_val[gi*N +: N];

            lim_digit #(.N(N)) u_digit (
                .value    (count_q[gi*N +: N]),
                .ci       (carry[gi]),
                .up       (up),
                .limit    (LIMW),
                .next_val (step_val[gi*N +: N]),
                .co       (carry[gi+1])
            );
        end
    endgenerate

    // Carry/borrow out of the top digit with a forced carry-in means every digit is terminal.
    assign tc = en & ~load & ~reset & carry[DIGITS];

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamp;
        end else if (en) begin
            if (!(tc && (SAT == SAT_HOLD))) begin
                count_d = step_val;
            end
            wrap_d = tc && (SAT == SAT_WRAP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_lim_digit_counter.sv
// Directed and random checks of wrap and saturate counter instances against
// a mixed-radix integer model (value modulo 10*6*10*6).
module tb_lim_digit_counter;

    localparam int M = 3600;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] count0, count1;
    logic        tc0, tc1, wrap0, wrap1;

    always #5 clk = ~clk;

    lim_digit_counter #(.DIGITS(4), .L_LO(10), .L_HI(6), .SAT(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count0), .tc(tc0), .wrap(wrap0)
    );

    lim_digit_counter #(.DIGITS(4), .L_LO(10), .L_HI(6), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1), .wrap(wrap1)
    );

    int total = 0;
    int bad = 0;
    int mv[2];
    bit mw[2];
    bit started = 1'b0;
    bit verbose = 1'b1;

    function automatic int clamp_val(input logic [15:0] lv);
        int lims[4] = '{10, 6, 10, 6};
        int w[4]    = '{1, 10, 60, 600};
        int v = 0;
        for (int k = 0; k < 4; k++) begin
            int d = int'(lv[k*4 +: 4]);
            if (d > lims[k] - 1) d = lims[k] - 1;
            v += d * w[k];
        end
        return v;
    endfunction

    function automatic logic [15:0] enc(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 6);
        r[11:8]  = 4'((v / 60) % 10);
        r[15:12] = 4'((v / 600) % 6);
        return r;
    endfunction

    function automatic bit exp_tc(input int v);
        return en && !load && !reset && (up ? (v == M - 1) : (v == 0));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: counter as a single integer in [0, M).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit t;
            t = exp_tc(mv[i]);
            if (reset) begin
                mv[i] = 0;
                mw[i] = 1'b0;
            end else if (load) begin
                mv[i] = clamp_val(load_val);
                mw[i] = 1'b0;
            end else if (en) begin
                if (t) begin
                    if (i == 0) begin
                        mv[i] = up ? 0 : M - 1;
                        mw[i] = 1'b1;
                    end else begin
                        mw[i] = 1'b0;
                    end
                end else begin
                    mv[i] = up ? mv[i] + 1 : mv[i] - 1;
                    mw[i] = 1'b0;
                end
            end else begin
                mw[i] = 1'b0;
            end
        end
        if (reset) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("count_wrapmode", 32'(count0), 32'(enc(mv[0])));
            check("wrap_wrapmode",  32'(wrap0),  32'(mw[0]));
            check("tc_wrapmode",    32'(tc0),    32'(exp_tc(mv[0])));
            check("count_satmode",  32'(count1), 32'(enc(mv[1])));
            check("wrap_satmode",   32'(wrap1),  32'(mw[1]));
            check("tc_satmode",     32'(tc1),    32'(exp_tc(mv[1])));
        end
    end

    task automatic drive(input bit r, input bit l, input logic [15:0] lv, input bit e, input bit u);
        @(posedge clk);
        #1;
        reset = r; load = l; load_val = lv; en = e; up = u;
        if (verbose)
            $display("txn t=%0t reset=%0d load=%0d load_val=%h en=%0d up=%0d", $time, r, l, lv, e, u);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held two cycles with en/up asserted.
        drive(1, 0, 16'h0000, 1, 1);
        drive(1, 0, 16'h0000, 1, 1);
        @(negedge clk);
        check("lit_reset_count", 32'(count0), 32'h0000);
        check("lit_reset_tc",    32'(tc0),    32'h0);
        check("lit_reset_wrap",  32'(wrap0),  32'h0);

        // Up with ripple carry.
        drive(0, 1, 16'h0959, 0, 0);
        drive(0, 0, 16'h0000, 1, 1);
        @(negedge clk);
        check("lit_0959", 32'(count0), 32'h0959);
        check("lit_0959_tc", 32'(tc0), 32'h0);
        idle();
        @(negedge clk);
        check("lit_1000", 32'(count0), 32'h1000);

        // Climb to terminal count and wrap.
        drive(0, 1, 16'h5958, 0, 0);
        drive(0, 0, 16'h0000, 1, 1);
        @(negedge clk);
        check("lit_5958_tc", 32'(tc0), 32'h0);
        drive(0, 0, 16'h0000, 1, 1);
        @(negedge clk);
        check("lit_5959", 32'(count0), 32'h5959);
        check("lit_5959_tc", 32'(tc0), 32'h1);
        idle();
        @(negedge clk);
        check("lit_wrap_up_count", 32'(count0), 32'h0000);
        check("lit_wrap_up_pulse", 32'(wrap0), 32'h1);
        check("lit_sat_up_hold", 32'(count1), 32'h5959);
        check("lit_sat_up_nowrap", 32'(wrap1), 32'h0);
        idle();
        @(negedge clk);
        check("lit_wrap_pulse_end", 32'(wrap0), 32'h0);

        // Down with borrow, then underflow.
        drive(0, 1, 16'h1000, 0, 0);
        drive(0, 0, 16'h0000, 1, 0);
        idle();
        @(negedge clk);
        check("lit_borrow_0959", 32'(count0), 32'h0959);
        drive(0, 1, 16'h0000, 0, 0);
        drive(0, 0, 16'h0000, 1, 0);
        @(negedge clk);
        check("lit_down_tc", 32'(tc0), 32'h1);
        check("lit_down_tc_sat", 32'(tc1), 32'h1);
        idle();
        @(negedge clk);
        check("lit_wrap_down", 32'(count0), 32'h5959);
        check("lit_wrap_down_pulse", 32'(wrap0), 32'h1);
        check("lit_sat_down_hold", 32'(count1), 32'h0000);

        // Clamp, then load beats en.
        drive(0, 1, 16'h7FAC, 0, 0);
        drive(0, 1, 16'h0000, 1, 1);
        @(negedge clk);
        check("lit_clamp", 32'(count0), 32'h5959);
        check("lit_load_en_tc", 32'(tc0), 32'h0);
        idle();
        @(negedge clk);
        check("lit_load_wins", 32'(count0), 32'h0000);

        // Saturate instance holds at the top for three enabled cycles.
        drive(0, 1, 16'h5959, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 16'h0000, 1, 1);
            @(negedge clk);
            check("lit_sat_hold_count", 32'(count1), 32'h5959);
            check("lit_sat_hold_tc", 32'(tc1), 32'h1);
            check("lit_sat_hold_wrap", 32'(wrap1), 32'h0);
        end

        // Reset overrides load and en mid-count.
        drive(0, 1, 16'h0345, 0, 0);
        drive(0, 0, 16'h0000, 1, 1);
        drive(1, 1, 16'h1234, 1, 1);
        @(negedge clk);
        check("lit_midreset_tc", 32'(tc0), 32'h0);
        idle();
        @(negedge clk);
        check("lit_midreset_count", 32'(count0), 32'h0000);
        check("lit_midreset_wrap", 32'(wrap0), 32'h0);

        // Random traffic, checked every cycle by the model compare.
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] lv;
            case ($urandom_range(0, 3))
                0: lv = 16'h5959;
                1: lv = 16'h0000;
                2: lv = 16'hFFFF;
                default: lv = 16'($urandom);
            endcase
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, lv,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end
        idle();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
